// File: rtl/ip2_scan_out_capture_if.sv
// ip2_scan_out_capture_if: control, scan stream and capture result bundle for the ip2 scan-out capture block.
interface ip2_scan_out_capture_if #(parameter int DEPTH = 768);
  logic             enable;
  logic [5:0]       clk_counter;
  logic [5:0]       sample_phase;
  logic             capture_start;
  logic [10:0]      capture_len;
  logic             scan_out;
  logic             expected_bit;
  logic [DEPTH-1:0] capture_reg;
  logic [10:0]      bit_cnt;
  logic             sample_strobe;
  logic             busy;
  logic             status_done;
  logic [10:0]      mismatch_cnt;
  modport master (
    output enable, clk_counter, sample_phase, capture_start, capture_len, scan_out, expected_bit,
    input  capture_reg, bit_cnt, sample_strobe, busy, status_done, mismatch_cnt
  );
  modport slave (
    input  enable, clk_counter, sample_phase, capture_start, capture_len, scan_out, expected_bit,
    output capture_reg, bit_cnt, sample_strobe, busy, status_done, mismatch_cnt
  );
endinterface

// File: rtl/ip2_scan_out_capture.sv
// ip2_scan_out_capture: samples scan_out once per bxclk phase match and de-serialises it into capture_reg.
// Optional per-bit compare against expected_bit when CMS_PIX28_SCAN_CAPTURE_COMPARE_EN is defined.
module ip2_scan_out_capture #(
  parameter int DEPTH    = 768,
  parameter int SYNC_STG = 2
) (
  input logic clk,
  input logic reset_not,
  ip2_scan_out_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
  localparam logic [10:0] DEPTH_L = 11'(DEPTH);
  state_t           state_q;
  logic [SYNC_STG-1:0] sync_q;
  logic [DEPTH-1:0] capture_reg_q, capture_reg_d;
  logic [10:0]      bit_cnt_q, bit_cnt_d, eff_len_q, eff_len_d, mismatch_cnt_q, mismatch_cnt_d;
  logic             sample_strobe_q, busy_q, status_done_q;
  logic             scan_sync, hit;
  assign scan_sync = sync_q[SYNC_STG-1];
  assign hit       = bus.clk_counter == bus.sample_phase;
  always_comb begin
    capture_reg_d = capture_reg_q >> 1;
    capture_reg_d[DEPTH-1] = scan_sync;
    bit_cnt_d = bit_cnt_q + 11'd1;
    eff_len_d = bus.capture_len > DEPTH_L ? DEPTH_L : bus.capture_len;
`ifdef CMS_PIX28_SCAN_CAPTURE_COMPARE_EN
    mismatch_cnt_d = (scan_sync != bus.expected_bit && mismatch_cnt_q != 11'h7FF) ? mismatch_cnt_q + 11'd1 : mismatch_cnt_q;
`else
    mismatch_cnt_d = 11'd0;
`endif
  end
  always_ff @(posedge clk or negedge reset_not) begin
    if (!reset_not) begin
      state_q         <= IDLE;
      sync_q          <= '0;
      capture_reg_q   <= '0;
      bit_cnt_q       <= '0;
      eff_len_q       <= '0;
      mismatch_cnt_q  <= '0;
      sample_strobe_q <= 1'b0;
      busy_q          <= 1'b0;
      status_done_q   <= 1'b0;
    end else begin
      sync_q          <= {sync_q[SYNC_STG-2:0], bus.scan_out};
      sample_strobe_q <= 1'b0;
      if (!bus.enable) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE, DONE: if (bus.capture_start) begin
            capture_reg_q  <= '0;
            bit_cnt_q      <= '0;
            mismatch_cnt_q <= '0;
            eff_len_q      <= eff_len_d;
            status_done_q  <= eff_len_d == 11'd0;
            busy_q         <= eff_len_d != 11'd0;
            state_q        <= eff_len_d == 11'd0 ? DONE : ARM;
          end
          // first phase match only aligns to the bxclk period
          ARM: if (hit) state_q <= CAPTURE;
          CAPTURE: if (hit) begin
            capture_reg_q   <= capture_reg_d;
            bit_cnt_q       <= bit_cnt_d;
            mismatch_cnt_q  <= mismatch_cnt_d;
            sample_strobe_q <= 1'b1;
            if (bit_cnt_d == eff_len_q) begin
              state_q       <= DONE;
              status_done_q <= 1'b1;
              busy_q        <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign bus.capture_reg   = capture_reg_q;
  assign bus.bit_cnt       = bit_cnt_q;
  assign bus.sample_strobe = sample_strobe_q;
  assign bus.busy          = busy_q;
  assign bus.status_done   = status_done_q;
  assign bus.mismatch_cnt  = mismatch_cnt_q;
endmodule
